// File: rtl/score_pkg.sv
// Shared types and constants for the game score path.
// Round width matches the combined output of the eight-player round combiner.
package score_pkg;

  localparam int ROUND_W     = 4;
  localparam int NUM_PLAYERS = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    WIN  = 3'd2,
    LOSE = 3'd3,
    DRAW = 3'd4
  } state_t;

endpackage

// File: rtl/sat_add.sv
// Signed saturating adder: a (A_W) + sign-extended b (B_W), clamped to A_W bits.
// Purely combinational; B_W must not exceed A_W.
module sat_add #(
  parameter int A_W = 8,
  parameter int B_W = 4
) (
  input  logic signed [A_W-1:0] i_a,
  input  logic signed [B_W-1:0] i_b,
  output logic signed [A_W-1:0] o_sum
);

  logic signed [A_W:0] w_a_ext;
  logic signed [A_W:0] w_b_ext;
  logic signed [A_W:0] w_sum;

  assign w_a_ext = {i_a[A_W-1], i_a};
  assign w_b_ext = {{(A_W+1-B_W){i_b[B_W-1]}}, i_b};
  assign w_sum   = w_a_ext + w_b_ext;

  // The top two bits disagree only when the result left the A_W-bit range.
  always_comb begin
    o_sum = w_sum[A_W-1:0];
    if (w_sum[A_W] != w_sum[A_W-1]) begin
      o_sum = w_sum[A_W] ? {1'b1, {(A_W-1){1'b0}}} : {1'b0, {(A_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/score_accumulator.sv
// Accumulates signed round sums into a saturating game total and decides WIN/LOSE/DRAW.
// One game per start pulse; rounds are accepted only while playing (round_ready).
module score_accumulator
  import score_pkg::*;
#(
  parameter int TOTAL_W    = 8,
  parameter int NUM_ROUNDS = 8,
  parameter int WIN_SCORE  = 12,
  parameter int LOSE_SCORE = -8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               round_valid,
  input  logic [3:0]         round_sum,
  output logic               round_ready,
  output logic [TOTAL_W-1:0] total,
  output logic [3:0]         rounds_done,
  output logic               win,
  output logic               lose,
  output logic               draw
);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic signed [TOTAL_W-1:0]  r_total;
  logic signed [TOTAL_W-1:0]  w_new_total;
  logic [3:0]                 r_rounds_done;
  logic [3:0]                 w_rounds_inc;
  logic                       w_accept;
  logic                       w_restart;

  sat_add #(
    .A_W (TOTAL_W),
    .B_W (ROUND_W)
  ) u_sat_add (
    .i_a   (r_total),
    .i_b   (round_sum),
    .o_sum (w_new_total)
  );

  assign w_accept     = (r_state == PLAY) && round_valid;
  assign w_restart    = (r_state != PLAY) && start;
  assign w_rounds_inc = r_rounds_done + 4'd1;

  // Thresholds are checked before the round limit so a final-round win/loss is not a draw.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      PLAY: begin
        if (w_accept) begin
          if (int'(w_new_total) >= WIN_SCORE) begin
            w_state_nxt = WIN;
          end else if (int'(w_new_total) <= LOSE_SCORE) begin
            w_state_nxt = LOSE;
          end else if (w_rounds_inc == 4'(NUM_ROUNDS)) begin
            w_state_nxt = DRAW;
          end
        end
      end
      IDLE, WIN, LOSE, DRAW: begin
        if (start) begin
          w_state_nxt = PLAY;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_total       <= '0;
      r_rounds_done <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_restart) begin
        r_total       <= '0;
        r_rounds_done <= '0;
      end else if (w_accept) begin
        r_total       <= w_new_total;
        r_rounds_done <= w_rounds_inc;
      end
    end
  end

  assign round_ready = (r_state == PLAY);
  assign win         = (r_state == WIN);
  assign lose        = (r_state == LOSE);
  assign draw        = (r_state == DRAW);
  assign total       = r_total;
  assign rounds_done = r_rounds_done;

endmodule

// File: tb/tb_score_accumulator.sv
// Two score_accumulator configurations driven with shared stimulus and checked every cycle
// against a per-instance game model, plus directed spot checks from the game rules.
module tb_score_accumulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       round_valid;
  logic [3:0] round_sum;

  logic       ready_a, win_a, lose_a, draw_a;
  logic [7:0] total_a;
  logic [3:0] rounds_a;
  logic       ready_b, win_b, lose_b, draw_b;
  logic [4:0] total_b;
  logic [3:0] rounds_b;

  int checks   = 0;
  int failures = 0;

  // Per-instance game parameters: [0] default build, [1] narrow saturation build.
  int p_w[2]    = '{8, 5};
  int p_win[2]  = '{12, 15};
  int p_lose[2] = '{-8, -8};
  int p_nr[2]   = '{8, 15};

  // Model: playing / game_over flags and an outcome code (1 win, 2 lose, 3 draw).
  bit m_play[2];
  int m_outcome[2];
  int m_total[2];
  int m_rounds[2];

  always #5 clk = ~clk;

  score_accumulator dut_a (
    .clk(clk), .reset(reset), .start(start), .round_valid(round_valid),
    .round_sum(round_sum), .round_ready(ready_a), .total(total_a),
    .rounds_done(rounds_a), .win(win_a), .lose(lose_a), .draw(draw_a)
  );

  score_accumulator #(
    .TOTAL_W(5), .NUM_ROUNDS(15), .WIN_SCORE(15), .LOSE_SCORE(-8)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start), .round_valid(round_valid),
    .round_sum(round_sum), .round_ready(ready_b), .total(total_b),
    .rounds_done(rounds_b), .win(win_b), .lose(lose_b), .draw(draw_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v, input int w);
    int lo = -(1 << (w - 1));
    int hi = (1 << (w - 1)) - 1;
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model_step(input int k);
    int s = round_sum[3] ? int'(round_sum) - 16 : int'(round_sum);
    if (reset) begin
      m_play[k] = 0; m_outcome[k] = 0; m_total[k] = 0; m_rounds[k] = 0;
    end else if (m_play[k]) begin
      if (round_valid) begin
        m_total[k]  = clamp(m_total[k] + s, p_w[k]);
        m_rounds[k] = m_rounds[k] + 1;
        if (m_total[k] >= p_win[k])       begin m_play[k] = 0; m_outcome[k] = 1; end
        else if (m_total[k] <= p_lose[k]) begin m_play[k] = 0; m_outcome[k] = 2; end
        else if (m_rounds[k] == p_nr[k])  begin m_play[k] = 0; m_outcome[k] = 3; end
      end
    end else if (start) begin
      m_play[k] = 1; m_outcome[k] = 0; m_total[k] = 0; m_rounds[k] = 0;
    end
  endtask

  task automatic compare_all();
    chk("a_total",  int'($signed(total_a)), m_total[0]);
    chk("a_rounds", int'(rounds_a), m_rounds[0]);
    chk("a_ready",  int'(ready_a), int'(m_play[0]));
    chk("a_win",    int'(win_a),  int'(m_outcome[0] == 1));
    chk("a_lose",   int'(lose_a), int'(m_outcome[0] == 2));
    chk("a_draw",   int'(draw_a), int'(m_outcome[0] == 3));
    chk("b_total",  int'($signed(total_b)), m_total[1]);
    chk("b_rounds", int'(rounds_b), m_rounds[1]);
    chk("b_ready",  int'(ready_b), int'(m_play[1]));
    chk("b_win",    int'(win_b),  int'(m_outcome[1] == 1));
    chk("b_lose",   int'(lose_b), int'(m_outcome[1] == 2));
    chk("b_draw",   int'(draw_b), int'(m_outcome[1] == 3));
  endtask

  // Apply inputs, take one clock edge, advance the model, then compare after the edge.
  task automatic drive(input logic r, input logic st, input logic v, input logic [3:0] s);
    reset = r; start = st; round_valid = v; round_sum = s;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; round_valid = 1'b0; round_sum = 4'd0;
    for (int k = 0; k < 2; k++) begin
      m_play[k] = 0; m_outcome[k] = 0; m_total[k] = 0; m_rounds[k] = 0;
    end
    #2;
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    chk("reset_total", int'(total_a), 0);
    chk("reset_ready", int'(ready_a), 0);

    // Win path: 3,6,9,12 then terminal
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 4'd3); chk("win_t1", int'($signed(total_a)), 3);
    drive(0, 0, 1, 4'd3); chk("win_t2", int'($signed(total_a)), 6);
    drive(0, 0, 1, 4'd3); chk("win_t3", int'($signed(total_a)), 9);
    drive(0, 0, 1, 4'd3); chk("win_t4", int'($signed(total_a)), 12);
    chk("win_flag", int'(win_a), 1);
    chk("win_rounds", int'(rounds_a), 4);
    chk("win_ready", int'(ready_a), 0);
    drive(0, 0, 1, 4'd3); chk("win_hold", int'($signed(total_a)), 12);

    // Lose path: -2 x4 reaches -8
    drive(0, 1, 0, 0);
    repeat (4) drive(0, 0, 1, 4'hE);
    chk("lose_total", int'(total_a), 8'hF8);
    chk("lose_flag", int'(lose_a), 1);
    chk("lose_rounds", int'(rounds_a), 4);

    // Draw path: +1 x8, ninth ignored
    drive(0, 1, 0, 0);
    repeat (8) drive(0, 0, 1, 4'd1);
    chk("draw_total", int'($signed(total_a)), 8);
    chk("draw_flag", int'(draw_a), 1);
    chk("draw_rounds", int'(rounds_a), 8);
    drive(0, 0, 1, 4'd1);
    chk("draw_hold", int'(rounds_a), 8);

    // Ignored inputs
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 4'd5);
    drive(0, 1, 1, 4'd5);
    chk("idle_ign_total", int'(total_a), 0);
    chk("idle_ign_rounds", int'(rounds_a), 0);
    drive(0, 1, 1, 4'd2);
    chk("play_start_total", int'($signed(total_a)), 2);
    chk("play_start_rounds", int'(rounds_a), 1);

    // Saturation on the narrow build
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 4'd7); chk("sat_t1", int'($signed(total_b)), 7);
    drive(0, 0, 1, 4'd7); chk("sat_t2", int'($signed(total_b)), 14);
    drive(0, 0, 1, 4'd7); chk("sat_t3", int'($signed(total_b)), 15);
    chk("sat_win", int'(win_b), 1);

    // Mid-game reset, then restart from WIN
    drive(0, 1, 0, 0);
    repeat (3) drive(0, 0, 1, 4'd2);
    drive(1, 0, 0, 0);
    chk("rst_total", int'(total_a), 0);
    chk("rst_rounds", int'(rounds_a), 0);
    chk("rst_ready", int'(ready_a), 0);
    drive(0, 1, 0, 0);
    repeat (4) drive(0, 0, 1, 4'd3);
    chk("pre_restart_win", int'(win_a), 1);
    drive(0, 1, 0, 0);
    chk("restart_ready", int'(ready_a), 1);
    chk("restart_total", int'(total_a), 0);
    chk("restart_win", int'(win_a), 0);

    // Randomized play
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) < 6),
            4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
